// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Serializes a 4-bit word into an external 4-stage shift register. Ser feeds
// the register data input and ShEn is its clock. One strobe is issued every
// PRESCALE clocks, and the word goes out LSB first.
//
// Parameter
//   PRESCALE   CLK cycles per shift strobe (2..255)
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   Start      begin a pass with Data (sampled only in IDLE)
//   Clr        synchronous abort back to IDLE
//   Data[3:0]  word to serialize
//   Rep        (SHIFT_SEQ_REPEAT_EN only) repeat the held word from DONE
//   Ser        serial bit to the shift register Din
//   ShEn       shift strobe to the shift register clock
//   Busy       high while not IDLE
//   Done       one-cycle completion pulse
//   Cnt[2:0]   strobes completed in the current pass
//
// Build option: define SHIFT_SEQ_REPEAT_EN to add the Rep input.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for Start; Ser low, Cnt holds last pass count
// S_SHIFT | prescaling and strobing the four bits out
// S_DONE  | one cycle with Done high, then IDLE (or SHIFT on Rep)
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Clr,
    input  logic [3:0] Data,
`ifdef SHIFT_SEQ_REPEAT_EN
    input  logic       Rep,
`endif
    output logic       Ser,
    output logic       ShEn,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] Cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [7:0] LP_PRE_TC = 8'(PRESCALE - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_hold,  w_hold_nxt;
    logic [7:0] r_pre,   w_pre_nxt;
    logic       r_ser,   w_ser_nxt;
    logic       r_shen,  w_shen_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic [2:0] r_cnt,   w_cnt_nxt;
    logic [1:0] w_nxt_idx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_pre   <= '0;
            r_ser   <= 1'b0;
            r_shen  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_pre   <= w_pre_nxt;
            r_ser   <= w_ser_nxt;
            r_shen  <= w_shen_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pre_nxt   = r_pre;
        w_ser_nxt   = r_ser;
        w_shen_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_nxt_idx   = r_cnt[1:0] + 2'd1;

        case (r_state)
            S_IDLE: begin
                w_ser_nxt = 1'b0;
                if (Start) begin
                    w_hold_nxt  = Data;
                    w_ser_nxt   = Data[0];
                    w_cnt_nxt   = '0;
                    w_pre_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_pre_nxt = r_pre + 8'd1;
                if (r_shen) begin
                    // Strobe falling edge: advance the bit and the count.
                    // Ser only moves here, so it is stable around each rise.
                    w_cnt_nxt = r_cnt + 3'd1;
                    w_ser_nxt = r_hold[w_nxt_idx];
                    if (r_cnt == 3'd3) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_ser_nxt   = 1'b0;
                        w_pre_nxt   = '0;
                    end
                end else if (r_pre == LP_PRE_TC) begin
                    w_shen_nxt = 1'b1;
                    w_pre_nxt  = '0;
                end
            end
            S_DONE: begin
                w_ser_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
`ifdef SHIFT_SEQ_REPEAT_EN
                // The DONE cycle counts toward the first prescale period of
                // the repeated pass, so strobes stay PRESCALE apart from the
                // edge that entered DONE.
                if (Rep) begin
                    w_ser_nxt   = r_hold[0];
                    w_cnt_nxt   = '0;
                    w_pre_nxt   = r_pre + 8'd1;
                    w_state_nxt = S_SHIFT;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ser_nxt   = 1'b0;
            end
        endcase

        if (Clr) begin
            w_state_nxt = S_IDLE;
            w_ser_nxt   = 1'b0;
            w_shen_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_pre_nxt   = '0;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign Ser  = r_ser;
    assign ShEn = r_shen;
    assign Busy = r_busy;
    assign Done = r_done;
    assign Cnt  = r_cnt;

endmodule
